// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the microcoded control sequencer and the datapath it drives.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] ST_IDLE = SEQ_IDLE;
  localparam logic [1:0] ST_RUN  = SEQ_RUN;
  localparam logic [1:0] ST_DONE = SEQ_DONE;

  // Control word field positions, shared with the datapath decode.
  localparam int unsigned CW_R1_E      = 0;
  localparam int unsigned CW_R2_E      = 1;
  localparam int unsigned CW_R3_E      = 2;
  localparam int unsigned CW_R4_E      = 3;
  localparam int unsigned CW_R1_OE     = 4;
  localparam int unsigned CW_R2_OE     = 5;
  localparam int unsigned CW_R3_OE     = 6;
  localparam int unsigned CW_R4_OE     = 7;
  localparam int unsigned CW_AU1_OP_LO = 8;
  localparam int unsigned CW_AU1_OP_HI = 11;
  localparam int unsigned CW_AU2_OP_LO = 12;
  localparam int unsigned CW_AU2_OP_HI = 15;
  localparam int unsigned CW_MISC_LO   = 16;
  localparam int unsigned CW_MISC_HI   = 19;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_ucode_rf.sv
// Microcode store: NSTEPS x CW flops, one sync write port, one combinational read port.
module ctrl_ucode_rf
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned NSTEPS = 12,
  parameter int unsigned CW     = 20,
  parameter int unsigned AW     = step_w(NSTEPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata_c,
  output logic          oor_c
);

  logic [CW-1:0] mem_q [NSTEPS];

  // Extra MSB keeps the compare valid when NSTEPS is a power of two.
  assign oor_c = {1'b0, waddr} >= (AW+1)'(NSTEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSTEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && !oor_c) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: step counter, loop counter and gated control word output.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned NSTEPS     = 12,
  parameter int unsigned CW         = 20,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOOP_START = 4,
  parameter int unsigned LOOP_END   = 9,
  parameter int unsigned SW         = step_w(NSTEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_iter,
  input  logic             stall,
  input  logic             uc_we,
  input  logic [SW-1:0]    uc_addr,
  input  logic [CW-1:0]    uc_wdata,
  output logic [CW-1:0]    ctrl,
  output logic [SW-1:0]    step,
  output logic             busy,
  output logic             done,
  output logic             uc_err
);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             uc_err_q, uc_err_d;
  logic             rf_we;
  logic             rf_oor_c;
  logic [CW-1:0]    rf_rdata_c;

  // The table only accepts writes while idle.
  assign rf_we = uc_we && (state_q == ST_IDLE);

  ctrl_ucode_rf #(
    .NSTEPS (NSTEPS),
    .CW     (CW),
    .AW     (SW)
  ) u_ucode_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (uc_addr),
    .wdata   (uc_wdata),
    .raddr   (step_q),
    .rdata_c (rf_rdata_c),
    .oor_c   (rf_oor_c)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    iter_d   = iter_q;
    uc_err_d = uc_we && ((state_q != ST_IDLE) || rf_oor_c);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          step_d  = '0;
          iter_d  = (n_iter == '0) ? CNT_W'(1) : n_iter;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if ((step_q == SW'(LOOP_END)) && (iter_q > CNT_W'(1))) begin
            step_d = SW'(LOOP_START);
            iter_d = iter_q - CNT_W'(1);
          end else if (step_q == SW'(NSTEPS - 1)) begin
            state_d = ST_DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      uc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      uc_err_q <= uc_err_d;
    end
  end

  // Control word comes only from flops: the run flag and the table entry at the current step.
  assign ctrl   = busy_q ? rf_rdata_c : '0;
  assign step   = step_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign uc_err = uc_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus queues expected output cycles, a monitor pops them.
module tb_ctrl_sequencer;
  import ctrl_seq_pkg::*;

  localparam int unsigned NSTEPS = 12;
  localparam int unsigned CW     = 20;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SW     = 4;
  localparam int          LS     = 4;
  localparam int          LE     = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_iter = '0;
  logic             stall = 1'b0;
  logic             uc_we = 1'b0;
  logic [SW-1:0]    uc_addr = '0;
  logic [CW-1:0]    uc_wdata = '0;
  logic [CW-1:0]    ctrl;
  logic [SW-1:0]    step;
  logic             busy;
  logic             done;
  logic             uc_err;

  always #5 clk = ~clk;

  ctrl_sequencer #(
    .NSTEPS(NSTEPS), .CW(CW), .CNT_W(CNT_W), .LOOP_START(LS), .LOOP_END(LE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_iter(n_iter), .stall(stall),
    .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .ctrl(ctrl), .step(step), .busy(busy), .done(done), .uc_err(uc_err)
  );

  typedef struct {
    logic [SW-1:0] step;
    logic [CW-1:0] ctrl;
    logic          busy;
    logic          done;
    logic          err;
    logic          chk_step;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          mon_e;
  logic [CW-1:0] tbl [NSTEPS];
  int            n_chk  = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;

  task automatic check(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  // Monitor: every cycle the DUT shows activity must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && rst_n && (busy || done || uc_err)) begin
      if (exp_q.size() == 0) begin
        check(1'b0, $sformatf("unexpected_out: got step=%0d ctrl=%h busy=%b done=%b err=%b, required no output",
                              step, ctrl, busy, done, uc_err));
      end else begin
        mon_e = exp_q.pop_front();
        check((ctrl === mon_e.ctrl) && (busy === mon_e.busy) && (done === mon_e.done) &&
              (uc_err === mon_e.err) && (!mon_e.chk_step || (step === mon_e.step)),
              $sformatf("out_cycle: got step=%0d ctrl=%h busy=%b done=%b err=%b, required step=%0d ctrl=%h busy=%b done=%b err=%b",
                        step, ctrl, busy, done, uc_err,
                        mon_e.step, mon_e.ctrl, mon_e.busy, mon_e.done, mon_e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      cyc();
      k++;
    end
    if (exp_q.size() > 0) begin
      check(1'b0, $sformatf("%s_timeout: got %0d outputs still pending, required 0", name, exp_q.size()));
      exp_q.delete();
    end
    check(busy === 1'b0 && done === 1'b0,
          $sformatf("%s_idle: got busy=%b done=%b, required 0 0", name, busy, done));
  endtask

  task automatic load_table();
    for (int i = 0; i < int'(NSTEPS); i++) begin
      uc_we    = 1'b1;
      uc_addr  = SW'(i);
      uc_wdata = CW'(i + 1);
      tbl[i]   = CW'(i + 1);
      cyc();
    end
    uc_we = 1'b0;
  endtask

  // One run: stall for stall_cyc cycles at cycle 5, rejected write at we_cyc, ignored start at restart_cyc.
  task automatic run(input int n, input int stall_cyc, input int we_cyc, input int restart_cyc,
                     input bit do_w0, input logic [CW-1:0] w0, input string name);
    rec_t recs[$];
    rec_t r;
    int   seq[$];
    int   nn;
    nn = (n == 0) ? 1 : n;
    if (do_w0) tbl[0] = w0;
    for (int s = 0; s <= LE; s++) seq.push_back(s);
    for (int k = 1; k < nn; k++)
      for (int s = LS; s <= LE; s++) seq.push_back(s);
    seq.push_back(10);
    seq.push_back(11);
    for (int i = 0; i < seq.size(); i++) begin
      r = '{SW'(seq[i]), tbl[seq[i]], 1'b1, 1'b0, 1'b0, 1'b1};
      recs.push_back(r);
      if (i == 5)
        for (int j = 0; j < stall_cyc; j++) recs.push_back(r);
    end
    r = '{'0, '0, 1'b0, 1'b1, 1'b0, 1'b0};
    recs.push_back(r);
    if (we_cyc >= 0) begin
      r = recs[we_cyc + 1];
      r.err = 1'b1;
      recs[we_cyc + 1] = r;
    end
    foreach (recs[i]) exp_q.push_back(recs[i]);

    start  = 1'b1;
    n_iter = CNT_W'(n);
    if (do_w0) begin
      uc_we    = 1'b1;
      uc_addr  = '0;
      uc_wdata = w0;
    end
    cyc();
    start = 1'b0;
    uc_we = 1'b0;
    for (int c = 0; c < recs.size(); c++) begin
      stall    = (c >= 5) && (c < 5 + stall_cyc);
      uc_we    = (c == we_cyc);
      uc_addr  = SW'(2);
      uc_wdata = CW'(20'hFEDCB);
      start    = (c == restart_cyc);
      cyc();
    end
    stall = 1'b0;
    uc_we = 1'b0;
    start = 1'b0;
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NSTEPS); i++) tbl[i] = '0;
    #3;
    check(ctrl === '0 && busy === 1'b0 && done === 1'b0,
          $sformatf("reset_out: got ctrl=%h busy=%b done=%b, required 0 0 0", ctrl, busy, done));
    check(step === '0 && uc_err === 1'b0,
          $sformatf("reset_step: got step=%0d uc_err=%b, required 0 0", step, uc_err));
    #9 rst_n = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Write step 3, then reset: the word must be cleared.
    uc_we    = 1'b1;
    uc_addr  = SW'(3);
    uc_wdata = CW'(20'hABCDE);
    cyc();
    uc_we = 1'b0;
    rst_n = 1'b0;
    #2;
    check(ctrl === '0 && busy === 1'b0 && done === 1'b0 && step === '0,
          $sformatf("reset_hold: got ctrl=%h busy=%b done=%b step=%0d, required 0 0 0 0", ctrl, busy, done, step));
    cyc();
    rst_n = 1'b1;
    cyc();
    run(1, 0, -1, -1, 1'b0, '0, "cleared_table");

    load_table();
    run(1, 0, -1, -1, 1'b0, '0, "single_pass");
    run(3, 0, -1, -1, 1'b0, '0, "loop3_restart");
    run(0, 0, -1, -1, 1'b0, '0, "n_iter_zero");
    run(1, 3, -1, -1, 1'b0, '0, "stall3");
    run(1, 0, 1, 3, 1'b0, '0, "run_reject");

    // Out-of-range write in IDLE.
    exp_q.push_back('{'0, '0, 1'b0, 1'b0, 1'b1, 1'b0});
    uc_we    = 1'b1;
    uc_addr  = SW'(12);
    uc_wdata = '1;
    cyc();
    uc_we = 1'b0;
    drain("idle_reject");

    run(1, 0, -1, -1, 1'b1, CW'(20'h00055), "start_with_write");
    run(2, 0, -1, -1, 1'b0, '0, "loop2");

    // Asynchronous reset in the middle of a run.
    mon_en = 1'b0;
    start  = 1'b1;
    n_iter = CNT_W'(1);
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    check(busy === 1'b1 && step === SW'(7) && ctrl === tbl[7],
          $sformatf("pre_reset: got busy=%b step=%0d ctrl=%h, required 1 7 %h", busy, step, ctrl, tbl[7]));
    #2 rst_n = 1'b0;
    #1;
    check(busy === 1'b0 && ctrl === '0 && done === 1'b0 && step === '0,
          $sformatf("async_reset: got busy=%b ctrl=%h done=%b step=%0d, required 0 0 0 0", busy, ctrl, done, step));
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check(busy === 1'b0 && done === 1'b0,
          $sformatf("stay_idle: got busy=%b done=%b, required 0 0", busy, done));
    exp_q.delete();
    for (int i = 0; i < int'(NSTEPS); i++) tbl[i] = '0;
    mon_en = 1'b1;
    run(2, 0, -1, -1, 1'b0, '0, "post_reset_cleared");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
